bcd10c_to_bin_seq: RTL and testbench



---
 rtl/bcd_conv_pkg.sv | 34 +++
 rtl/bcd_digit_mac.sv | 14 +
 rtl/bcd10c_to_bin_seq.sv | 159 +++++++++++++++
 tb/tb_bcd10c_to_bin_seq.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/bcd_conv_pkg.sv
// Shared types and elaboration-time helpers for the ten's-complement BCD to binary converter.
package bcd_conv_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ACC  = 2'd1,
    FIX  = 2'd2,
    OUT  = 2'd3
  } conv_state_e;

  function automatic logic [63:0] pow10(input int n);
    logic [63:0] p;
    p = 64'd1;
    for (int i = 0; i < n; i++) begin
      p = (p << 3'd3) + (p << 3'd1);
    end
    return p;
  endfunction

  // Smallest W with 2^W >= 10^n10, i.e. 2^(W-1) >= 10^n10 / 2.
  function automatic int min_width(input int n10);
    logic [63:0] p;
    int          w;
    p = pow10(n10);
    w = 64;
    for (int i = 63; i >= 0; i--) begin
      if ((64'd1 << i) >= p) begin
        w = i;
      end
    end
    return w;
  endfunction

endpackage

// File: rtl/bcd_digit_mac.sv
// One multiply-by-ten accumulate step (acc*10 + digit, mod 2^W) with an invalid-digit flag.
module bcd_digit_mac #(
  parameter int W = 7
) (
  input  logic [W-1:0] acc_i,
  input  logic [3:0]   digit_i,
  output logic [W-1:0] acc_o,
  output logic         bad_o
);

  assign acc_o = (acc_i << 3'd3) + (acc_i << 3'd1) + {{(W-4){1'b0}}, digit_i};
  assign bad_o = (digit_i > 4'd9);

endmodule

// File: rtl/bcd10c_to_bin_seq.sv
// Digit-serial N10-digit ten's-complement BCD to W-bit two's-complement converter.
// Define BCD_CHECK_EN to flag digits above 9 on err and force A2 to zero for such operands.
module bcd10c_to_bin_seq
  import bcd_conv_pkg::*;
#(
  parameter int N10 = 2,
  parameter int W   = 7
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            start,
  input  logic [4*N10-1:0] A10,
  output logic            ready,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [W-1:0]    A2,
  output logic            err
);

  localparam int              DW       = 4 * N10;
  localparam int              CW       = (N10 > 1) ? $clog2(N10) : 1;
  localparam logic [CW-1:0]   CNT_LOAD = CW'(N10 - 1);
  localparam logic [CW-1:0]   CNT_ONE  = CW'(1);
  localparam logic [63:0]     POW_FULL = pow10(N10);
  localparam logic [W-1:0]    POW_W    = POW_FULL[W-1:0];
  localparam logic [3:0]      NEG_MIN  = 4'd5;

  if ((W < min_width(N10)) || (W > 64)) begin : g_width_check
    $error("bcd10c_to_bin_seq: W cannot hold every N10-digit ten's-complement value");
  end

  conv_state_e   state_q, state_d;
  logic [DW-1:0] sh_q, sh_d;
  logic [W-1:0]  acc_q, acc_d;
  logic [W-1:0]  a2_q, a2_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          neg_q, neg_d;
  logic          bad_q, bad_d;
  logic          err_q, err_d;
  logic          ready_q, ready_d;
  logic          valid_q, valid_d;

  logic [3:0]    digit_s;
  logic [W-1:0]  mac_s;
  logic [W-1:0]  fix_s;
  logic          dig_bad_s;

  assign digit_s = sh_q[DW-1 -: 4];
  assign fix_s   = neg_q ? (acc_q - POW_W) : acc_q;

  bcd_digit_mac #(.W(W)) u_mac (
    .acc_i   (acc_q),
    .digit_i (digit_s),
    .acc_o   (mac_s),
    .bad_o   (dig_bad_s)
  );

`ifndef BCD_CHECK_EN
  logic unused_bad_s;
  assign unused_bad_s = bad_q;
`endif

  // Next-state and datapath: ready/out_valid are decoded from the next state so they register cleanly.
  always_comb begin
    state_d = state_q;
    sh_d    = sh_q;
    acc_d   = acc_q;
    a2_d    = a2_q;
    cnt_d   = cnt_q;
    neg_d   = neg_q;
    bad_d   = bad_q;
    err_d   = err_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          sh_d    = A10;
          acc_d   = {W{1'b0}};
          cnt_d   = CNT_LOAD;
          neg_d   = (A10[DW-1 -: 4] >= NEG_MIN);
          bad_d   = 1'b0;
          state_d = ACC;
        end else begin
          state_d = IDLE;
        end
      end
      ACC: begin
        acc_d = mac_s;
        sh_d  = sh_q << 4'd4;
        bad_d = bad_q | dig_bad_s;
        if (cnt_q == {CW{1'b0}}) begin
          state_d = FIX;
        end else begin
          cnt_d   = cnt_q - CNT_ONE;
          state_d = ACC;
        end
      end
      FIX: begin
`ifdef BCD_CHECK_EN
        if (bad_q) begin
          a2_d  = {W{1'b0}};
          err_d = 1'b1;
        end else begin
          a2_d  = fix_s;
          err_d = 1'b0;
        end
`else
        a2_d  = fix_s;
        err_d = 1'b0;
`endif
        state_d = OUT;
      end
      OUT: begin
        if (out_ready) begin
          state_d = IDLE;
        end else begin
          state_d = OUT;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    ready_d = (state_d == IDLE);
    valid_d = (state_d == OUT);
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= IDLE;
      sh_q    <= {DW{1'b0}};
      acc_q   <= {W{1'b0}};
      a2_q    <= {W{1'b0}};
      cnt_q   <= {CW{1'b0}};
      neg_q   <= 1'b0;
      bad_q   <= 1'b0;
      err_q   <= 1'b0;
      ready_q <= 1'b1;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      sh_q    <= sh_d;
      acc_q   <= acc_d;
      a2_q    <= a2_d;
      cnt_q   <= cnt_d;
      neg_q   <= neg_d;
      bad_q   <= bad_d;
      err_q   <= err_d;
      ready_q <= ready_d;
      valid_q <= valid_d;
    end
  end

  assign ready     = ready_q;
  assign out_valid = valid_q;
  assign A2        = a2_q;
  assign err       = err_q;

endmodule

// File: tb/tb_bcd10c_to_bin_seq.sv
// Bench for bcd10c_to_bin_seq: arithmetic reference model with per-cycle compare plus directed literal checks.
module tb_bcd10c_to_bin_seq;

  localparam int N1 = 2;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [7:0]  a10 = 8'h00;
  logic        out_ready = 1'b1;
  logic        ready, out_valid, err;
  logic [6:0]  a2;

  logic        start2 = 1'b0;
  logic [11:0] a10_2 = 12'h000;
  logic        out_ready2 = 1'b1;
  logic        ready2, out_valid2, err2;
  logic [10:0] a2_2;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clock = ~clock;

  bcd10c_to_bin_seq #(.N10(2), .W(7)) dut (
    .clock(clock), .reset(reset), .start(start), .A10(a10), .ready(ready),
    .out_valid(out_valid), .out_ready(out_ready), .A2(a2), .err(err)
  );

  bcd10c_to_bin_seq #(.N10(3), .W(11)) dut3 (
    .clock(clock), .reset(reset), .start(start2), .A10(a10_2), .ready(ready2),
    .out_valid(out_valid2), .out_ready(out_ready2), .A2(a2_2), .err(err2)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic ref_bad(input logic [63:0] a, input int n);
    logic b;
    b = 1'b0;
    for (int i = 0; i < n; i++) begin
      if (a[4*i +: 4] > 4'd9) b = 1'b1;
    end
    return b;
  endfunction

  function automatic logic ref_err(input logic [63:0] a, input int n);
`ifdef BCD_CHECK_EN
    return ref_bad(a, n);
`else
    return 1'b0;
`endif
  endfunction

  // Signed value of the digit string, wrapped to w bits.
  function automatic logic [63:0] ref_val(input logic [63:0] a, input int n, input int w);
    longint v, p;
    v = 0;
    p = 1;
    for (int i = 0; i < n; i++) begin
      v = v + longint'(a[4*i +: 4]) * p;
      p = p * 10;
    end
    if (a[4*(n-1) +: 4] >= 4'd5) v = v - p;
    if (ref_err(a, n)) v = 0;
    return 64'(v) & ((64'd1 << w) - 64'd1);
  endfunction

  logic       m_ready = 1'b1, m_valid = 1'b0, m_err = 1'b0, p_err = 1'b0;
  logic [6:0] m_a2 = 7'd0, p_a2 = 7'd0;
  int         m_wait = 0;

  // Transaction-level model of the N10=2 instance, compared just after every edge.
  always @(posedge clock) begin
    if (reset) begin
      m_ready = 1'b1; m_valid = 1'b0; m_a2 = 7'd0; m_err = 1'b0; m_wait = 0;
    end else if (m_wait != 0) begin
      m_wait = m_wait - 1;
      if (m_wait == 0) begin
        m_valid = 1'b1; m_a2 = p_a2; m_err = p_err;
      end
    end else if (m_ready) begin
      if (start) begin
        m_ready = 1'b0;
        m_wait  = N1 + 1;
        p_a2    = 7'(ref_val(64'(a10), N1, 7));
        p_err   = ref_err(64'(a10), N1);
      end
    end else if (m_valid && out_ready) begin
      m_valid = 1'b0;
      m_ready = 1'b1;
    end
    #1;
    chk("model_ready", 64'(ready), 64'(m_ready));
    chk("model_out_valid", 64'(out_valid), 64'(m_valid));
    chk("model_A2", 64'(a2), 64'(m_a2));
    chk("model_err", 64'(err), 64'(m_err));
  end

  task automatic convert(input logic [7:0] v, input logic [6:0] exp_a2, input logic exp_err, input string tag);
    int lat;
    @(negedge clock);
    start = 1'b1; a10 = v;
    @(negedge clock);
    start = 1'b0; a10 = 8'hEE;
    lat = 1;
    while (!out_valid && lat < 20) begin
      @(negedge clock);
      lat++;
    end
    chk({tag, "_latency"}, 64'(lat), 64'd4);
    chk({tag, "_A2"}, 64'(a2), 64'(exp_a2));
    chk({tag, "_err"}, 64'(err), 64'(exp_err));
    @(negedge clock);
  endtask

  task automatic convert3(input logic [11:0] v, input logic [10:0] exp_a2, input string tag);
    int lat;
    @(negedge clock);
    chk({tag, "_ready"}, 64'(ready2), 64'd1);
    start2 = 1'b1; a10_2 = v;
    @(negedge clock);
    start2 = 1'b0;
    lat = 1;
    while (!out_valid2 && lat < 20) begin
      @(negedge clock);
      lat++;
    end
    chk({tag, "_latency"}, 64'(lat), 64'd5);
    chk({tag, "_A2"}, 64'(a2_2), 64'(exp_a2));
    chk({tag, "_err"}, 64'(err2), 64'd0);
    @(negedge clock);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, n_bad=%0d", n_bad);
    $fatal(1, "watchdog");
  end

  initial begin
    chk("pin_ref_h05", ref_val(64'h05, 2, 7), 64'h05);
    chk("pin_ref_h69", ref_val(64'h69, 2, 7), 64'h61);
    chk("pin_ref_h500", ref_val(64'h500, 3, 11), 64'h60C);

    repeat (3) @(negedge clock);
    chk("rst_ready", 64'(ready), 64'd1);
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_A2", 64'(a2), 64'd0);
    chk("rst_err", 64'(err), 64'd0);
    reset = 1'b0;

    convert(8'h05, 7'b000_0101, 1'b0, "p05");
    convert(8'h15, 7'b000_1111, 1'b0, "p15");
    convert(8'h99, 7'b111_1111, 1'b0, "m01");
    convert(8'h69, 7'b110_0001, 1'b0, "m31");
    convert(8'h49, 7'b011_0001, 1'b0, "p49");
    convert(8'h50, 7'b100_1110, 1'b0, "m50");
`ifdef BCD_CHECK_EN
    convert(8'h1A, 7'd0, 1'b1, "bad1a");
`else
    convert(8'h1A, 7'd20, 1'b0, "raw1a");
`endif
    convert(8'h15, 7'b000_1111, 1'b0, "after1a");

    // Back-pressure: result must hold and new starts must be ignored.
    @(negedge clock);
    out_ready = 1'b0; start = 1'b1; a10 = 8'h15;
    @(negedge clock);
    start = 1'b0;
    for (int i = 0; i < 20 && !out_valid; i++) @(negedge clock);
    for (int i = 0; i < 5; i++) begin
      start = 1'b1; a10 = 8'h33;
      @(negedge clock);
      chk("bp_out_valid", 64'(out_valid), 64'd1);
      chk("bp_A2", 64'(a2), 64'h0F);
      chk("bp_ready", 64'(ready), 64'd0);
    end
    start = 1'b0; out_ready = 1'b1;
    @(negedge clock);
    chk("bp_done_valid", 64'(out_valid), 64'd0);
    chk("bp_done_ready", 64'(ready), 64'd1);

    // Reset in the middle of accumulation discards the conversion.
    start = 1'b1; a10 = 8'h99;
    @(negedge clock);
    start = 1'b0; reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    chk("rstacc_ready", 64'(ready), 64'd1);
    chk("rstacc_A2", 64'(a2), 64'd0);
    chk("rstacc_err", 64'(err), 64'd0);
    for (int i = 0; i < 8; i++) begin
      chk("rstacc_no_valid", 64'(out_valid), 64'd0);
      @(negedge clock);
    end

    // start held high: back-to-back conversions sampling fresh operands.
    start = 1'b1;
    for (int i = 0; i < 24; i++) begin
      a10 = {4'($urandom_range(0, 9)), 4'($urandom_range(0, 9))};
      @(negedge clock);
    end
    start = 1'b0;
    repeat (8) @(negedge clock);

    // Random operands (including non-BCD digits) with random back-pressure.
    for (int i = 0; i < 60; i++) begin
      start     = 1'($urandom_range(0, 1));
      a10       = 8'($urandom);
      out_ready = 1'($urandom_range(0, 1));
      @(negedge clock);
    end
    start = 1'b0; out_ready = 1'b1;
    repeat (8) @(negedge clock);

    convert3(12'h500, 11'b110_0000_1100, "n3_m500");
    convert3(12'h499, 11'b001_1111_0011, "n3_p499");

    repeat (2) @(negedge clock);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
